alu_ram_imem: RTL and testbench

ALU_RAM_IMEM -- requirements
Module: alu_ram_imem

---
 rtl/alu_ram_imem.sv | 107 ++++++++++
 tb/tb_alu_ram_imem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ram_imem.sv
// ALU with registered result, 16x16 data RAM and 16x16 writable instruction memory.
// Memories clear to their reset contents asynchronously; all reads are combinational.
module alu_ram_imem (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [2:0]  alu_sel,
   input  logic [3:0]  shamt,
   input  logic        alu_en,
   output logic [15:0] alu_y,
   output logic        carry_out,
   output logic [15:0] alu_q,
   output logic        carry_q,
   input  logic [3:0]  ram_addr,
   input  logic [15:0] ram_wdata,
   input  logic        ram_we,
   input  logic        ram_oe,
   output logic [15:0] ram_rdata,
   input  logic [3:0]  pc,
   output logic [15:0] ins,
   input  logic        imem_we,
   input  logic [3:0]  imem_waddr,
   input  logic [15:0] imem_wdata
);

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 16;
   localparam logic [DW-1:0] HALT_INS = 16'h9000;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_NAND = 3'b110;
   localparam logic [2:0] OP_LSL  = 3'b111;

   logic [DW:0]   w_sum;
   logic [DW:0]   w_diff;
   logic [DW-1:0] w_y;
   logic          w_carry;

   logic [DW-1:0] r_alu_q;
   logic          r_carry_q;
   logic [DW-1:0] r_ram  [DEPTH];
   logic [DW-1:0] r_imem [DEPTH];

   // Subtraction as a + ~b + 1 so the carry reads as "no borrow".
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);

   always_comb begin
      w_y     = '0;
      w_carry = 1'b0;
      case (alu_sel)
         OP_ADD:  begin w_y = w_sum[DW-1:0];  w_carry = w_sum[DW];  end
         OP_SUB:  begin w_y = w_diff[DW-1:0]; w_carry = w_diff[DW]; end
         OP_AND:  w_y = a & b;
         OP_OR:   w_y = a | b;
         OP_XOR:  w_y = a ^ b;
         OP_NOR:  w_y = ~(a | b);
         OP_NAND: w_y = ~(a & b);
         OP_LSL:  w_y = a << shamt;
         default: w_y = '0;
      endcase
   end

   assign alu_y     = w_y;
   assign carry_out = w_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_q   <= '0;
         r_carry_q <= 1'b0;
      end else if (alu_en) begin
         r_alu_q   <= w_y;
         r_carry_q <= w_carry;
      end
   end

   assign alu_q   = r_alu_q;
   assign carry_q = r_carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
      end else if (ram_we) begin
         r_ram[ram_addr] <= ram_wdata;
      end
   end

   // Read port is gated off during a write so a write never echoes on the bus.
   assign ram_rdata = (ram_oe && !ram_we) ? r_ram[ram_addr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_imem[i] <= HALT_INS;
      end else if (imem_we) begin
         r_imem[imem_waddr] <= imem_wdata;
      end
   end

   assign ins = r_imem[pc];

endmodule

// File: tb/tb_alu_ram_imem.sv
// Directed bench for alu_ram_imem: expected values queued when stimulus is
// applied, popped and compared when the corresponding output is sampled.
module tb_alu_ram_imem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a, b;
   logic [2:0]  alu_sel;
   logic [3:0]  shamt;
   logic        alu_en;
   logic [15:0] alu_y;
   logic        carry_out;
   logic [15:0] alu_q;
   logic        carry_q;
   logic [3:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we, ram_oe;
   logic [15:0] ram_rdata;
   logic [3:0]  pc;
   logic [15:0] ins;
   logic        imem_we;
   logic [3:0]  imem_waddr;
   logic [15:0] imem_wdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [16:0] exp;
   } sb_t;
   sb_t sb_q[$];

   alu_ram_imem dut (
      .clk(clk), .rst_n(rst_n),
      .a(a), .b(b), .alu_sel(alu_sel), .shamt(shamt), .alu_en(alu_en),
      .alu_y(alu_y), .carry_out(carry_out), .alu_q(alu_q), .carry_q(carry_q),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
      .ram_rdata(ram_rdata),
      .pc(pc), .ins(ins),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [16:0] e);
      sb_t s;
      s.tag = tag;
      s.exp = e;
      sb_q.push_back(s);
   endtask

   task automatic pop_check(input logic [16:0] obs);
      sb_t s;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty observed=%h expected=<none>", obs);
         return;
      end
      s = sb_q.pop_front();
      assert (obs === s.exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.exp);
      end
   endtask

   // Reference ALU written independently of the RTL formulation.
   function automatic logic [16:0] alu_model(input logic [2:0] sel, input logic [15:0] x,
                                             input logic [15:0] y, input logic [3:0] sh);
      int unsigned s;
      case (sel)
         3'd0: begin s = 32'(x) + 32'(y); return {s[16], s[15:0]}; end
         3'd1: begin s = 32'(x) - 32'(y); return {(x >= y), s[15:0]}; end
         3'd2: return {1'b0, x & y};
         3'd3: return {1'b0, x | y};
         3'd4: return {1'b0, x ^ y};
         3'd5: return {1'b0, ~(x | y)};
         3'd6: return {1'b0, ~(x & y)};
         default: begin s = 32'(x) * (32'd1 << sh); return {1'b0, s[15:0]}; end
      endcase
   endfunction

   task automatic alu_case(input string tag, input logic [2:0] sel, input logic [15:0] x,
                           input logic [15:0] y, input logic [3:0] sh, input logic [16:0] e);
      alu_sel = sel; a = x; b = y; shamt = sh;
      push_exp(tag, e);
      #1;
      pop_check({carry_out, alu_y});
   endtask

   initial begin
      rst_n = 1'b0;
      a = '0; b = '0; alu_sel = '0; shamt = '0; alu_en = 1'b0;
      ram_addr = '0; ram_wdata = '0; ram_we = 1'b0; ram_oe = 1'b0;
      pc = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

      // Reset state, with captures and writes attempted across an edge in reset
      #2;
      push_exp("rst_alu_q", 17'h0);
      pop_check({carry_q, alu_q});
      a = 16'hFFFF; b = 16'h0001; alu_en = 1'b1;
      ram_we = 1'b1; ram_addr = 4'd1; ram_wdata = 16'h1111;
      imem_we = 1'b1; imem_waddr = 4'd1; imem_wdata = 16'h2222;
      @(posedge clk); #1;
      push_exp("rst_no_capture", 17'h0);
      pop_check({carry_q, alu_q});
      @(negedge clk);
      alu_en = 1'b0; ram_we = 1'b0; imem_we = 1'b0;
      ram_oe = 1'b1;
      #1;
      push_exp("rst_ram1_no_write", 17'h0);
      pop_check({1'b0, ram_rdata});
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pc = 4'(i);
         push_exp($sformatf("imem_halt_%0d", i), {1'b0, 16'h9000});
         #1;
         pop_check({1'b0, ins});
      end

      // ALU directed cases
      @(negedge clk);
      alu_case("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 4'd0, {1'b1, 16'h0000});
      alu_case("sub_5_7",   3'd1, 16'd5,    16'd7,    4'd0, {1'b0, 16'hFFFE});
      alu_case("sub_7_5",   3'd1, 16'd7,    16'd5,    4'd0, {1'b1, 16'h0002});
      alu_case("and",       3'd2, 16'hF0F0, 16'h0FF0, 4'd0, {1'b0, 16'h00F0});
      alu_case("or",        3'd3, 16'hF0F0, 16'h0FF0, 4'd0, {1'b0, 16'hFFF0});
      alu_case("xor",       3'd4, 16'hF0F0, 16'h0FF0, 4'd0, {1'b0, 16'hFF00});
      alu_case("nor",       3'd5, 16'hF0F0, 16'h0FF0, 4'd0, {1'b0, 16'h000F});
      alu_case("nand",      3'd6, 16'hF0F0, 16'h0FF0, 4'd0, {1'b0, 16'hFF0F});
      alu_case("lsl_1",     3'd7, 16'h8001, 16'h0000, 4'd1, {1'b0, 16'h0002});
      alu_case("lsl_15",    3'd7, 16'h8001, 16'h0000, 4'd15, {1'b0, 16'h8000});
      alu_case("sub_equal", 3'd1, 16'h1234, 16'h1234, 4'd0, {1'b1, 16'h0000});

      for (int i = 0; i < 16; i++) begin
         logic [2:0]  rs;
         logic [15:0] ra, rb;
         logic [3:0]  rh;
         rs = 3'(i % 8);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rh = 4'($urandom_range(0, 15));
         alu_case($sformatf("alu_rand_%0d", i), rs, ra, rb, rh, alu_model(rs, ra, rb, rh));
      end

      // Register capture, hold, and asynchronous clear
      @(negedge clk);
      alu_sel = 3'd0; a = 16'd3; b = 16'd4; alu_en = 1'b1;
      @(posedge clk); #1;
      alu_en = 1'b0;
      push_exp("cap_7", {1'b0, 16'd7});
      pop_check({carry_q, alu_q});
      a = 16'd100; b = 16'd200;
      @(posedge clk); #1;
      push_exp("hold_7", {1'b0, 16'd7});
      pop_check({carry_q, alu_q});
      rst_n = 1'b0;
      #1;
      push_exp("async_clr", 17'h0);
      pop_check({carry_q, alu_q});
      @(negedge clk);
      rst_n = 1'b1;

      // Registered carry with a carrying add
      alu_sel = 3'd0; a = 16'hFFFF; b = 16'h0002; alu_en = 1'b1;
      @(posedge clk); #1;
      alu_en = 1'b0;
      push_exp("cap_carry", {1'b1, 16'h0001});
      pop_check({carry_q, alu_q});

      // RAM write/read/enable behaviour
      @(negedge clk);
      ram_addr = 4'd3; ram_oe = 1'b1; ram_we = 1'b0;
      push_exp("ram3_before", 17'h0);
      #1; pop_check({1'b0, ram_rdata});
      ram_we = 1'b1; ram_wdata = 16'hBEEF;
      push_exp("ram_we_oe", 17'h0);
      #1; pop_check({1'b0, ram_rdata});
      @(posedge clk); #1;
      ram_we = 1'b0;
      push_exp("ram3_beef", {1'b0, 16'hBEEF});
      #1; pop_check({1'b0, ram_rdata});
      ram_oe = 1'b0;
      push_exp("ram_oe0", 17'h0);
      #1; pop_check({1'b0, ram_rdata});
      ram_oe = 1'b1; ram_addr = 4'd4;
      push_exp("ram4_zero", 17'h0);
      #1; pop_check({1'b0, ram_rdata});
      @(negedge clk);
      ram_addr = 4'd15; ram_we = 1'b1; ram_wdata = 16'h5A5A;
      @(posedge clk); #1;
      ram_we = 1'b0;
      push_exp("ram15", {1'b0, 16'h5A5A});
      #1; pop_check({1'b0, ram_rdata});

      // IMem load, pre-edge old value, wrap address
      @(negedge clk);
      pc = 4'd0; imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 16'h0123;
      push_exp("imem0_pre", {1'b0, 16'h9000});
      #1; pop_check({1'b0, ins});
      @(posedge clk); #1;
      imem_we = 1'b0;
      push_exp("imem0_load", {1'b0, 16'h0123});
      #1; pop_check({1'b0, ins});
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = 4'd15; imem_wdata = 16'hABCD;
      @(posedge clk); #1;
      imem_we = 1'b0; pc = 4'd15;
      push_exp("imem15", {1'b0, 16'hABCD});
      #1; pop_check({1'b0, ins});
      pc = 4'd0;
      push_exp("imem0_kept", {1'b0, 16'h0123});
      #1; pop_check({1'b0, ins});

      // Reset falls between edges with a write pending
      @(negedge clk);
      ram_addr = 4'd5; ram_wdata = 16'h7777; ram_we = 1'b1; ram_oe = 1'b0;
      #2;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      ram_we = 1'b0; ram_oe = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ram_addr = 4'(i);
         push_exp($sformatf("ram_clr_%0d", i), 17'h0);
         #1;
         pop_check({1'b0, ram_rdata});
      end
      pc = 4'd0;
      push_exp("imem_reload_halt", {1'b0, 16'h9000});
      #1; pop_check({1'b0, ins});

      // First write after release lands on the first edge
      @(negedge clk);
      ram_addr = 4'd2; ram_wdata = 16'h2222; ram_we = 1'b1;
      @(posedge clk); #1;
      ram_we = 1'b0;
      push_exp("ram_post_rst", {1'b0, 16'h2222});
      #1; pop_check({1'b0, ram_rdata});

      checks++;
      assert (sb_q.size() == 0)
      else begin
         errors++;
         $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
